// File: rtl/pong_menu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pong_menu_pkg
//  Description : Shared geometry, colour constants and FSM state encoding for
//                the Pong start-menu renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_menu_pkg;

    // Menu item placement on the 640x480 VGA raster
    localparam logic [9:0] ITEM_X0    = 10'd288;
    localparam logic [9:0] ITEM_Y0    = 10'd200;
    localparam logic [9:0] ITEM_W     = 10'd64;
    localparam logic [9:0] ITEM_H     = 10'd32;
    localparam logic [9:0] ITEM_PITCH = 10'd48;
    localparam int         NUM_ITEMS  = 3;
    localparam logic [1:0] LAST_ITEM  = 2'(NUM_ITEMS - 1);

    // Colour applied to a selected item whose ROM texel is black, and mask
    // that darkens unselected items
    localparam logic [7:0] HILITE     = 8'b0000_0011;
    localparam logic [7:0] DIM_MASK   = 8'b0110_1101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_NAV      = 2'd1,
        S_CONFIRM  = 2'd2,
        S_WAIT_REL = 2'd3
    } menu_state_e;

    // Top scan line of item idx
    function automatic logic [9:0] item_y0(input logic [1:0] idx);
        return ITEM_Y0 + ITEM_PITCH * {8'b0000_0000, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_menu_renderer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : pong_menu_renderer_if
//  Description : Pixel, button, menu-ROM and status signals of the menu
//                renderer. The slave modport is the renderer; the master
//                modport is the video timing / button / ROM environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pong_menu_renderer_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       btn_up;
    logic       btn_down;
    logic       btn_select;
    logic       menu_active;
    logic [9:0] rom_row;
    logic [9:0] rom_col;
    logic [7:0] rom_color;
    logic [7:0] rgb;
    logic [1:0] item_sel;
    logic       start_game;
    logic [1:0] choice;

    modport slave (
        input  pixel_x, pixel_y, video_on,
        input  btn_up, btn_down, btn_select, menu_active,
        input  rom_color,
        output rom_row, rom_col,
        output rgb, item_sel, start_game, choice
    );

    modport master (
        output pixel_x, pixel_y, video_on,
        output btn_up, btn_down, btn_select, menu_active,
        output rom_color,
        input  rom_row, rom_col,
        input  rgb, item_sel, start_game, choice
    );
endinterface
`default_nettype wire

// File: rtl/pong_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pong_btn_edge
//  Description : Rising-edge detector for one debounced, clk-synchronous
//                button. The previous-value register resets to 1 so a button
//                already held when reset releases produces no edge.
//  Ports       : clk, reset_n (sync, active-low), i_btn level, o_rise pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_btn_edge (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_btn,
    output logic      o_rise
);
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/pong_menu_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : pong_menu_renderer
//  Description : Draws the three-item Pong start menu from a texture ROM and
//                runs the up/down/select navigation FSM.
//  Ports       : clk, reset_n (sync, active-low)
//                bus.pixel_x/pixel_y/video_on  - current raster position
//                bus.btn_up/btn_down/btn_select/menu_active - controls
//                bus.rom_row/rom_col -> ROM, bus.rom_color <- ROM (1 cycle)
//                bus.rgb (pixel t appears at t+3), bus.item_sel,
//                bus.start_game (one-cycle pulse), bus.choice
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_menu_renderer
    import pong_menu_pkg::*;
(
    input wire logic            clk,
    input wire logic            reset_n,
    pong_menu_renderer_if.slave bus
);
    // ------------------------------------------------------------------
    // Button edges
    // ------------------------------------------------------------------
    logic w_up_rise, w_dn_rise, w_sel_rise;

    pong_btn_edge u_edge_up  (.clk(clk), .reset_n(reset_n), .i_btn(bus.btn_up),     .o_rise(w_up_rise));
    pong_btn_edge u_edge_dn  (.clk(clk), .reset_n(reset_n), .i_btn(bus.btn_down),   .o_rise(w_dn_rise));
    pong_btn_edge u_edge_sel (.clk(clk), .reset_n(reset_n), .i_btn(bus.btn_select), .o_rise(w_sel_rise));

    // ------------------------------------------------------------------
    // Item hit test on the incoming pixel
    // ------------------------------------------------------------------
    logic       w_in_x, w_hit;
    logic [1:0] w_idx;
    logic [4:0] w_yoff;
    logic [5:0] w_xoff;

    assign w_in_x = (bus.pixel_x >= ITEM_X0) && (bus.pixel_x < ITEM_X0 + ITEM_W);
    assign w_xoff = 6'(bus.pixel_x - ITEM_X0);

    always_comb begin
        w_hit  = 1'b0;
        w_idx  = 2'd0;
        w_yoff = 5'd0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if ((bus.pixel_y >= item_y0(2'(i))) &&
                (bus.pixel_y <  item_y0(2'(i)) + ITEM_H)) begin
                w_hit  = w_in_x;
                w_idx  = 2'(i);
                w_yoff = 5'(bus.pixel_y - item_y0(2'(i)));
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 holds the ROM address, stage 2 lines up with
    // the ROM data, the rgb register is the third stage.
    // ------------------------------------------------------------------
    logic [9:0]  r_rom_row, r_rom_col;
    logic        r_s1_hit, r_s1_von, r_s2_hit, r_s2_von;
    logic [1:0]  r_s1_idx, r_s2_idx;
    logic [7:0]  r_rgb, w_rgb;
    logic [1:0]  r_item_sel, w_sel_nxt;
    logic [1:0]  r_choice, w_choice_nxt;
    menu_state_e r_state, w_state_nxt;

    always_comb begin
        w_rgb = 8'd0;
        if (r_s2_von && bus.menu_active && r_s2_hit) begin
            if (r_s2_idx == r_item_sel) begin
                w_rgb = (bus.rom_color != 8'd0) ? bus.rom_color : HILITE;
            end else begin
                w_rgb = bus.rom_color & DIM_MASK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rom_row <= 10'd0;
            r_rom_col <= 10'd0;
            r_s1_hit  <= 1'b0;
            r_s1_von  <= 1'b0;
            r_s1_idx  <= 2'd0;
            r_s2_hit  <= 1'b0;
            r_s2_von  <= 1'b0;
            r_s2_idx  <= 2'd0;
            r_rgb     <= 8'd0;
        end else begin
            r_rom_row <= w_hit ? {3'b000, w_idx, w_yoff} : 10'd0;
            r_rom_col <= w_hit ? {4'b0000, w_xoff}       : 10'd0;
            r_s1_hit  <= w_hit;
            r_s1_von  <= bus.video_on;
            r_s1_idx  <= w_idx;
            r_s2_hit  <= r_s1_hit;
            r_s2_von  <= r_s1_von;
            r_s2_idx  <= r_s1_idx;
            r_rgb     <= w_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Navigation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_item_sel <= 2'd0;
            r_choice   <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_item_sel <= w_sel_nxt;
            r_choice   <= w_choice_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_item_sel;
        w_choice_nxt = r_choice;
        if (!bus.menu_active) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_NAV;
                S_NAV: begin
                    // Select wins: choice takes the pre-update item and any
                    // simultaneous up/down edge is dropped.
                    if (w_sel_rise) begin
                        w_state_nxt  = S_CONFIRM;
                        w_choice_nxt = r_item_sel;
                    end else if (w_up_rise && !w_dn_rise) begin
                        w_sel_nxt = (r_item_sel == 2'd0) ? LAST_ITEM : r_item_sel - 2'd1;
                    end else if (w_dn_rise && !w_up_rise) begin
                        w_sel_nxt = (r_item_sel == LAST_ITEM) ? 2'd0 : r_item_sel + 2'd1;
                    end
                end
                S_CONFIRM:  w_state_nxt = S_WAIT_REL;
                S_WAIT_REL: if (!bus.btn_select) w_state_nxt = S_NAV;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.rom_row    = r_rom_row;
    assign bus.rom_col    = r_rom_col;
    assign bus.rgb        = r_rgb;
    assign bus.item_sel   = r_item_sel;
    assign bus.choice     = r_choice;
    assign bus.start_game = (r_state == S_CONFIRM);
endmodule
`default_nettype wire

// File: tb/tb_pong_menu_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_menu_renderer
//  Description : Self-checking bench for pong_menu_renderer. A behavioural
//                model tracks the menu rules and is compared against the DUT
//                every cycle; hand-computed literals pin key cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_menu_renderer;
    logic clk;
    logic reset_n;
    pong_menu_renderer_if ifc();

    pong_menu_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    logic [7:0] rom_pat = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Texture ROM: a few pinned texels, zero whenever col[2:0]==7
    function automatic logic [7:0] rom_fn(input logic [9:0] r, input logic [9:0] c);
        if (r == 10'd0 && c == 10'd0) return 8'hFF;
        if (r == 10'd32 && c == 10'd5) return rom_pat;
        if (c[2:0] == 3'd7) return 8'h00;
        return {r[6:5], r[2:0], c[2:0]};
    endfunction

    always @(posedge clk) ifc.rom_color <= rom_fn(ifc.rom_row, ifc.rom_col);

    // Screen geometry expressed directly from the item rectangles
    function automatic void geom(input int x, input int y, output bit hit,
                                 output int idx, output int xo, output int yo);
        hit = 0; idx = 0; xo = 0; yo = 0;
        for (int i = 0; i < 3; i++) begin
            if (x >= 288 && x <= 351 && y >= 200 + 48*i && y <= 231 + 48*i) begin
                hit = 1; idx = i; xo = x - 288; yo = y - (200 + 48*i);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    localparam int MIDLE = 0, MNAV = 1, MCONF = 2, MWAIT = 3;
    int         m_st, m_sel, m_ch;
    bit         m_pu, m_pd, m_ps;
    bit         s1_hit, s1_von, s2_hit, s2_von;
    int         s1_idx, s2_idx, s1_row, s1_col;
    logic [7:0] s2_color, m_rgb;

    always @(posedge clk) begin
        bit h, eu, ed, es;
        int gi, gx, gy;
        if (!reset_n) begin
            m_st = MIDLE; m_sel = 0; m_ch = 0;
            m_pu = 1; m_pd = 1; m_ps = 1;
            s1_hit = 0; s1_von = 0; s1_idx = 0; s1_row = 0; s1_col = 0;
            s2_hit = 0; s2_von = 0; s2_idx = 0; s2_color = 8'h00;
            m_rgb = 8'h00;
        end else begin
            if (s2_von && ifc.menu_active && s2_hit) begin
                if (s2_idx == m_sel) m_rgb = (s2_color != 8'h00) ? s2_color : 8'h03;
                else                 m_rgb = s2_color & 8'h6D;
            end else begin
                m_rgb = 8'h00;
            end
            s2_hit = s1_hit; s2_von = s1_von; s2_idx = s1_idx;
            s2_color = rom_fn(10'(s1_row), 10'(s1_col));
            geom(int'(ifc.pixel_x), int'(ifc.pixel_y), h, gi, gx, gy);
            s1_hit = h; s1_von = ifc.video_on; s1_idx = gi;
            s1_row = h ? gi*32 + gy : 0;
            s1_col = h ? gx : 0;

            eu = ifc.btn_up && !m_pu;
            ed = ifc.btn_down && !m_pd;
            es = ifc.btn_select && !m_ps;
            if (!ifc.menu_active) m_st = MIDLE;
            else case (m_st)
                MIDLE: m_st = MNAV;
                MNAV: begin
                    if (es) begin m_ch = m_sel; m_st = MCONF; end
                    else if (eu && !ed) m_sel = (m_sel + 2) % 3;
                    else if (ed && !eu) m_sel = (m_sel + 1) % 3;
                end
                MCONF: m_st = MWAIT;
                default: if (!ifc.btn_select) m_st = MNAV;
            endcase
            m_pu = ifc.btn_up; m_pd = ifc.btn_down; m_ps = ifc.btn_select;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rgb",        32'(ifc.rgb),        32'(m_rgb));
            check("rom_row",    32'(ifc.rom_row),    32'(s1_row));
            check("rom_col",    32'(ifc.rom_col),    32'(s1_col));
            check("item_sel",   32'(ifc.item_sel),   32'(m_sel));
            check("start_game", 32'(ifc.start_game), 32'(m_st == MCONF));
            check("choice",     32'(ifc.choice),     32'(m_ch));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic px(input int x, input int y, input bit v);
        ifc.pixel_x = 10'(x); ifc.pixel_y = 10'(y); ifc.video_on = v;
    endtask

    initial begin
        int cnt;
        int xs[5]  = '{287, 288, 300, 351, 352};
        int ys[12] = '{199, 200, 231, 232, 247, 248, 279, 280, 295, 296, 327, 328};
        reset_n = 1'b0;
        ifc.menu_active = 1'b0;
        ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_select = 1'b0;
        px(0, 0, 0);
        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("rst_item_sel", 32'(ifc.item_sel),   0);
        check("rst_rgb",      32'(ifc.rgb),        0);
        check("rst_start",    32'(ifc.start_game), 0);
        check("rst_choice",   32'(ifc.choice),     0);
        check("rst_rom_row",  32'(ifc.rom_row),    0);

        reset_n = 1'b1; ifc.menu_active = 1'b1;
        tick(2);

        // Top-left corner of item 0, selected, ROM FF
        px(288, 200, 1); tick(1);
        check("corner_row", 32'(ifc.rom_row), 0);
        check("corner_col", 32'(ifc.rom_col), 0);
        px(0, 0, 0); tick(2);
        check("corner_rgb", 32'(ifc.rgb), 32'h FF);

        // Selected item with black texel -> highlight colour
        px(295, 200, 1); tick(1); px(0, 0, 0); tick(2);
        check("hilite_rgb", 32'(ifc.rgb), 32'h03);

        // Unselected item 1 with ROM 0, then ROM FF -> dimmed
        rom_pat = 8'h00;
        px(293, 248, 1); tick(1);
        check("it1_row", 32'(ifc.rom_row), 32);
        check("it1_col", 32'(ifc.rom_col), 5);
        px(0, 0, 0); tick(2);
        check("it1_rgb_zero", 32'(ifc.rgb), 0);
        rom_pat = 8'hFF;
        px(293, 248, 1); tick(1); px(0, 0, 0); tick(2);
        check("it1_rgb_dim", 32'(ifc.rgb), 32'h6D);

        // Boundary scan, video_on alternating
        foreach (xs[i]) foreach (ys[j]) begin
            px(xs[i], ys[j], ((i + j) % 3) != 0); tick(1);
        end
        px(0, 0, 0); tick(3);

        // Navigation with wrap
        ifc.btn_up = 1; tick(1); ifc.btn_up = 0; tick(1);
        check("up_wrap", 32'(ifc.item_sel), 2);
        px(300, 296, 1); tick(1); px(0, 0, 0); tick(2);
        check("it2_sel_rgb", 32'(ifc.rgb), 32'h84);
        ifc.btn_down = 1; tick(1); ifc.btn_down = 0; tick(1);
        check("down_wrap", 32'(ifc.item_sel), 0);
        ifc.btn_up = 1; ifc.btn_down = 1; tick(1);
        ifc.btn_up = 0; ifc.btn_down = 0; tick(1);
        check("both_hold", 32'(ifc.item_sel), 0);
        ifc.btn_down = 1; tick(1); ifc.btn_down = 0; tick(1);
        check("down_to_1", 32'(ifc.item_sel), 1);

        // Select held 10 cycles -> one pulse
        ifc.btn_select = 1; cnt = 0;
        repeat (10) begin tick(1); cnt += int'(ifc.start_game); end
        check("held_one_pulse", 32'(cnt), 1);
        check("choice_1", 32'(ifc.choice), 1);
        ifc.btn_select = 0; tick(2);
        ifc.btn_select = 1; tick(1);
        check("repress_start", 32'(ifc.start_game), 1);
        tick(1);
        ifc.btn_up = 1; tick(1); ifc.btn_up = 0; tick(1);
        check("up_ignored_wait", 32'(ifc.item_sel), 1);

        // Menu dropped during WAIT_REL
        ifc.menu_active = 0; px(300, 210, 1); tick(3);
        check("off_rgb",   32'(ifc.rgb), 0);
        check("off_start", 32'(ifc.start_game), 0);
        check("off_sel",   32'(ifc.item_sel), 1);

        // Select held while menu comes up -> no pulse
        ifc.menu_active = 1; cnt = 0;
        repeat (6) begin tick(1); cnt += int'(ifc.start_game); end
        check("held_entry_nostart", 32'(cnt), 0);

        // Select and down in the same cycle
        ifc.btn_select = 0; tick(1);
        ifc.btn_up = 1; tick(1); ifc.btn_up = 0; tick(1);
        ifc.btn_select = 1; ifc.btn_down = 1; tick(1);
        check("seldn_start",  32'(ifc.start_game), 1);
        check("seldn_choice", 32'(ifc.choice), 0);
        check("seldn_sel",    32'(ifc.item_sel), 0);
        ifc.btn_down = 0; tick(1);

        // Reset during CONFIRM
        ifc.btn_select = 0; tick(1);
        ifc.btn_down = 1; tick(1); ifc.btn_down = 0; tick(1);
        ifc.btn_select = 1; tick(1);
        check("pre_rst_start", 32'(ifc.start_game), 1);
        reset_n = 0; tick(1);
        check("rst_cf_start", 32'(ifc.start_game), 0);
        check("rst_cf_sel",   32'(ifc.item_sel), 0);
        check("rst_cf_rgb",   32'(ifc.rgb), 0);
        reset_n = 1; tick(1);
        check("post_rst_start", 32'(ifc.start_game), 0);
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
